// File: rtl/rob_pkg.sv
// rob_pkg: shared definitions for the reorder buffer.
//   ROB_WIDTH_DEF : default index width (depth = 2**ROB_WIDTH_DEF)
//   ROB_SIZE      : default number of entries
//   rob_state_e   : per-entry lifecycle EMPTY -> ISSUED -> READY -> EMPTY
//   NO_REG        : destination id used when an instruction writes no register
package rob_pkg;

    localparam int ROB_WIDTH_DEF = 4;
    localparam int ROB_SIZE      = 2 ** ROB_WIDTH_DEF;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ISSUED = 2'd1,
        ST_READY  = 2'd2
    } rob_state_e;

    localparam logic [4:0] NO_REG = 5'd0;

endpackage

// File: rtl/rob.sv
// rob: reorder buffer, a circular queue of in-flight instructions.
//   Optional feature macro: ROB_WB_BYPASS_EN (search sees a same-cycle CDB write).
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (low freezes all state)
//   issue_*        : allocation from the decoder; issue_rob_id / rob_full back
//   wb_*           : common data bus writeback (value, branch outcome, target)
//   commit_*       : in-order retirement to the register file (registered)
//   search_*_1/_2  : two combinational operand-forwarding lookups
//   clear / redirect_pc : one-cycle flush on a committed branch mispredict
module rob
    import rob_pkg::*;
#(
    parameter int ROB_WIDTH = ROB_WIDTH_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 issue_valid,
    input  logic                 issue_has_rd,
    input  logic [4:0]           issue_rd,
    input  logic                 issue_is_branch,
    input  logic                 issue_pred_taken,
    output logic [ROB_WIDTH-1:0] issue_rob_id,
    output logic                 rob_full,
    input  logic                 wb_valid,
    input  logic [ROB_WIDTH-1:0] wb_rob_id,
    input  logic [31:0]          wb_val,
    input  logic                 wb_taken,
    input  logic [31:0]          wb_target,
    output logic                 commit_ready,
    output logic [4:0]           commit_reg_id,
    output logic [31:0]          commit_val,
    output logic [ROB_WIDTH-1:0] commit_rob_id,
    input  logic [ROB_WIDTH-1:0] search_rob_id_1,
    input  logic [ROB_WIDTH-1:0] search_rob_id_2,
    output logic                 search_ready_1,
    output logic [31:0]          search_val_1,
    output logic                 search_ready_2,
    output logic [31:0]          search_val_2,
    output logic                 clear,
    output logic [31:0]          redirect_pc
);

    localparam int DEPTH = 2 ** ROB_WIDTH;
    localparam logic [ROB_WIDTH:0]   FULL_CNT = {1'b1, {ROB_WIDTH{1'b0}}};
    localparam logic [ROB_WIDTH:0]   CNT_ONE  = {{ROB_WIDTH{1'b0}}, 1'b1};
    localparam logic [ROB_WIDTH-1:0] PTR_ONE  = {{(ROB_WIDTH-1){1'b0}}, 1'b1};

    rob_state_e          r_state  [DEPTH];
    logic [4:0]          r_rd     [DEPTH];
    logic [31:0]         r_val    [DEPTH];
    logic                r_is_br  [DEPTH];
    logic                r_pred   [DEPTH];
    logic                r_taken  [DEPTH];
    logic [31:0]         r_target [DEPTH];

    logic [ROB_WIDTH-1:0] r_head;
    logic [ROB_WIDTH-1:0] r_tail;
    logic [ROB_WIDTH:0]   r_count;

    logic                 r_commit_ready;
    logic [4:0]           r_commit_reg_id;
    logic [31:0]          r_commit_val;
    logic [ROB_WIDTH-1:0] r_commit_rob_id;
    logic                 r_clear;
    logic [31:0]          r_redirect_pc;

    logic w_full;
    logic w_issue;
    logic w_wb;
    logic w_commit;
    logic w_mispredict;

    // Per-cycle control decisions, all derived from registered state.
    always_comb begin
        w_full       = (r_count == FULL_CNT);
        w_issue      = issue_valid && !w_full;
        w_wb         = wb_valid && (r_state[wb_rob_id] == ST_ISSUED);
        w_commit     = (r_state[r_head] == ST_READY);
        w_mispredict = w_commit && r_is_br[r_head] && (r_taken[r_head] != r_pred[r_head]);
    end

    // Entry array, pointers, occupancy and registered commit/flush outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i]  <= ST_EMPTY;
                r_rd[i]     <= NO_REG;
                r_val[i]    <= 32'd0;
                r_is_br[i]  <= 1'b0;
                r_pred[i]   <= 1'b0;
                r_taken[i]  <= 1'b0;
                r_target[i] <= 32'd0;
            end
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= '0;
            r_commit_ready  <= 1'b0;
            r_commit_reg_id <= NO_REG;
            r_commit_val    <= 32'd0;
            r_commit_rob_id <= '0;
            r_clear         <= 1'b0;
            r_redirect_pc   <= 32'd0;
        end else if (rdy_in) begin
            r_commit_ready <= w_commit;
            r_clear        <= w_mispredict;
            if (w_commit) begin
                // A flushing branch still retires, but never writes a register.
                r_commit_reg_id <= w_mispredict ? NO_REG : r_rd[r_head];
                r_commit_val    <= r_val[r_head];
                r_commit_rob_id <= r_head;
            end
            if (w_mispredict) begin
                r_redirect_pc <= r_target[r_head];
                // Same-cycle issue and writeback are dropped with the flush.
                for (int i = 0; i < DEPTH; i++) begin
                    r_state[i] <= ST_EMPTY;
                end
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                // wb only hits ISSUED entries, issue only the EMPTY tail and
                // commit only the READY head, so these never collide.
                if (w_wb) begin
                    r_state[wb_rob_id]  <= ST_READY;
                    r_val[wb_rob_id]    <= wb_val;
                    r_taken[wb_rob_id]  <= wb_taken;
                    r_target[wb_rob_id] <= wb_target;
                end
                if (w_issue) begin
                    r_state[r_tail] <= ST_ISSUED;
                    r_rd[r_tail]    <= issue_has_rd ? issue_rd : NO_REG;
                    r_is_br[r_tail] <= issue_is_branch;
                    r_pred[r_tail]  <= issue_pred_taken;
                    r_tail          <= r_tail + PTR_ONE;
                end
                if (w_commit) begin
                    r_state[r_head] <= ST_EMPTY;
                    r_head          <= r_head + PTR_ONE;
                end
                case ({w_issue, w_commit})
                    2'b10:   r_count <= r_count + CNT_ONE;
                    2'b01:   r_count <= r_count - CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Operand-forwarding lookups for the register file.
    always_comb begin
        search_ready_1 = (r_state[search_rob_id_1] == ST_READY);
        search_val_1   = search_ready_1 ? r_val[search_rob_id_1] : 32'd0;
        search_ready_2 = (r_state[search_rob_id_2] == ST_READY);
        search_val_2   = search_ready_2 ? r_val[search_rob_id_2] : 32'd0;
`ifdef ROB_WB_BYPASS_EN
        // The live CDB value wins over the stored entry state.
        if (w_wb && (wb_rob_id == search_rob_id_1)) begin
            search_ready_1 = 1'b1;
            search_val_1   = wb_val;
        end else begin
            search_ready_1 = search_ready_1;
        end
        if (w_wb && (wb_rob_id == search_rob_id_2)) begin
            search_ready_2 = 1'b1;
            search_val_2   = wb_val;
        end else begin
            search_ready_2 = search_ready_2;
        end
`endif
    end

    assign issue_rob_id  = r_tail;
    assign rob_full      = w_full;
    assign commit_ready  = r_commit_ready;
    assign commit_reg_id = r_commit_reg_id;
    assign commit_val    = r_commit_val;
    assign commit_rob_id = r_commit_rob_id;
    assign clear         = r_clear;
    assign redirect_pc   = r_redirect_pc;

endmodule

// File: tb/tb_rob.sv
// tb_rob: directed, table-driven bench for the reorder buffer.
module tb_rob;

`ifdef ROB_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        issue_valid;
    logic        issue_has_rd;
    logic [4:0]  issue_rd;
    logic        issue_is_branch;
    logic        issue_pred_taken;
    logic [3:0]  issue_rob_id;
    logic        rob_full;
    logic        wb_valid;
    logic [3:0]  wb_rob_id;
    logic [31:0] wb_val;
    logic        wb_taken;
    logic [31:0] wb_target;
    logic        commit_ready;
    logic [4:0]  commit_reg_id;
    logic [31:0] commit_val;
    logic [3:0]  commit_rob_id;
    logic [3:0]  search_rob_id_1;
    logic [3:0]  search_rob_id_2;
    logic        search_ready_1;
    logic [31:0] search_val_1;
    logic        search_ready_2;
    logic [31:0] search_val_2;
    logic        clear;
    logic [31:0] redirect_pc;

    int total = 0;
    int bad   = 0;

    rob dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_has_rd(issue_has_rd), .issue_rd(issue_rd),
        .issue_is_branch(issue_is_branch), .issue_pred_taken(issue_pred_taken),
        .issue_rob_id(issue_rob_id), .rob_full(rob_full),
        .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_val(wb_val),
        .wb_taken(wb_taken), .wb_target(wb_target),
        .commit_ready(commit_ready), .commit_reg_id(commit_reg_id),
        .commit_val(commit_val), .commit_rob_id(commit_rob_id),
        .search_rob_id_1(search_rob_id_1), .search_rob_id_2(search_rob_id_2),
        .search_ready_1(search_ready_1), .search_val_1(search_val_1),
        .search_ready_2(search_ready_2), .search_val_2(search_val_2),
        .clear(clear), .redirect_pc(redirect_pc)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        iv;
        logic [4:0]  rd;
        logic        wv;
        logic [3:0]  wid;
        logic [31:0] wval;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [3:0]  e_id;
        logic        e_sr1;
        logic [31:0] e_sv1;
        logic        e_sr2;
        logic [31:0] e_sv2;
        logic        e_cr;
        logic [4:0]  e_creg;
        logic [31:0] e_cval;
        logic [3:0]  e_cid;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_has_rd = 1'b0; issue_rd = 5'd0;
        issue_is_branch = 1'b0; issue_pred_taken = 1'b0;
        wb_valid = 1'b0; wb_rob_id = 4'd0; wb_val = 32'd0;
        wb_taken = 1'b0; wb_target = 32'd0;
        search_rob_id_1 = 4'd0; search_rob_id_2 = 4'd0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rdy_in = 1'b1;
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        chk("rst_commit_ready", {31'd0, commit_ready}, 32'd0);
        chk("rst_commit_reg", {27'd0, commit_reg_id}, 32'd0);
        chk("rst_commit_val", commit_val, 32'd0);
        chk("rst_commit_id", {28'd0, commit_rob_id}, 32'd0);
        chk("rst_clear", {31'd0, clear}, 32'd0);
        chk("rst_redirect", redirect_pc, 32'd0);
        chk("rst_issue_id", {28'd0, issue_rob_id}, 32'd0);
        chk("rst_full", {31'd0, rob_full}, 32'd0);
    endtask

    function automatic vec_t mk(input logic iv, input logic [4:0] rd, input logic wv,
                                input logic [3:0] wid, input logic [31:0] wval,
                                input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] e_id,
                                input logic e_sr1, input logic [31:0] e_sv1,
                                input logic e_sr2, input logic [31:0] e_sv2,
                                input logic e_cr, input logic [4:0] e_creg,
                                input logic [31:0] e_cval, input logic [3:0] e_cid);
        vec_t v;
        v.iv = iv; v.rd = rd; v.wv = wv; v.wid = wid; v.wval = wval;
        v.s1 = s1; v.s2 = s2; v.e_id = e_id;
        v.e_sr1 = e_sr1; v.e_sv1 = e_sv1; v.e_sr2 = e_sr2; v.e_sv2 = e_sv2;
        v.e_cr = e_cr; v.e_creg = e_creg; v.e_cval = e_cval; v.e_cid = e_cid;
        return v;
    endfunction

    initial begin
        // In-order retire of one result, then out-of-order writeback 3,2,1.
        tbl[0]  = mk(1'b1, 5'd5, 1'b0, 4'd0, 32'h0,    4'd0, 4'd0,  4'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 4'd0);
        tbl[1]  = mk(1'b0, 5'd0, 1'b1, 4'd0, 32'h1234, 4'd0, 4'd15, 4'd1, BYP, BYP ? 32'h1234 : 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 4'd0);
        tbl[2]  = mk(1'b0, 5'd0, 1'b0, 4'd0, 32'h0,    4'd0, 4'd0,  4'd1, 1'b1, 32'h1234, 1'b1, 32'h1234, 1'b1, 5'd5, 32'h1234, 4'd0);
        tbl[3]  = mk(1'b0, 5'd0, 1'b0, 4'd0, 32'h0,    4'd0, 4'd0,  4'd1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 4'd0);
        tbl[4]  = mk(1'b1, 5'd1, 1'b0, 4'd0, 32'h0,    4'd1, 4'd1,  4'd1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 4'd0);
        tbl[5]  = mk(1'b1, 5'd2, 1'b0, 4'd0, 32'h0,    4'd1, 4'd2,  4'd2, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 4'd0);
        tbl[6]  = mk(1'b1, 5'd3, 1'b0, 4'd0, 32'h0,    4'd1, 4'd2,  4'd3, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 4'd0);
        tbl[7]  = mk(1'b0, 5'd0, 1'b1, 4'd3, 32'h33,   4'd1, 4'd3,  4'd4, 1'b0, 32'h0, BYP, BYP ? 32'h33 : 32'h0, 1'b0, 5'd0, 32'h0, 4'd0);
        tbl[8]  = mk(1'b0, 5'd0, 1'b1, 4'd2, 32'h22,   4'd3, 4'd2,  4'd4, 1'b1, 32'h33, BYP, BYP ? 32'h22 : 32'h0, 1'b0, 5'd0, 32'h0, 4'd0);
        tbl[9]  = mk(1'b0, 5'd0, 1'b1, 4'd1, 32'h11,   4'd2, 4'd1,  4'd4, 1'b1, 32'h22, BYP, BYP ? 32'h11 : 32'h0, 1'b0, 5'd0, 32'h0, 4'd0);
        tbl[10] = mk(1'b0, 5'd0, 1'b0, 4'd0, 32'h0,    4'd1, 4'd3,  4'd4, 1'b1, 32'h11, 1'b1, 32'h33, 1'b1, 5'd1, 32'h11, 4'd1);
        tbl[11] = mk(1'b0, 5'd0, 1'b0, 4'd0, 32'h0,    4'd1, 4'd2,  4'd4, 1'b0, 32'h0, 1'b1, 32'h22, 1'b1, 5'd2, 32'h22, 4'd2);
        tbl[12] = mk(1'b0, 5'd0, 1'b0, 4'd0, 32'h0,    4'd2, 4'd3,  4'd4, 1'b0, 32'h0, 1'b1, 32'h33, 1'b1, 5'd3, 32'h33, 4'd3);
        tbl[13] = mk(1'b0, 5'd0, 1'b0, 4'd0, 32'h0,    4'd3, 4'd0,  4'd4, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 4'd0);

        rst_in = 1'b1;
        rdy_in = 1'b1;
        idle();
        tick();
        do_reset();

        for (int i = 0; i < 14; i++) begin
            issue_valid = tbl[i].iv; issue_has_rd = (tbl[i].rd != 5'd0); issue_rd = tbl[i].rd;
            issue_is_branch = 1'b0; issue_pred_taken = 1'b0;
            wb_valid = tbl[i].wv; wb_rob_id = tbl[i].wid; wb_val = tbl[i].wval;
            wb_taken = 1'b0; wb_target = 32'd0;
            search_rob_id_1 = tbl[i].s1; search_rob_id_2 = tbl[i].s2;
            #1;
            chk($sformatf("v%0d_issue_id", i), {28'd0, issue_rob_id}, {28'd0, tbl[i].e_id});
            chk($sformatf("v%0d_full", i), {31'd0, rob_full}, 32'd0);
            chk($sformatf("v%0d_sready1", i), {31'd0, search_ready_1}, {31'd0, tbl[i].e_sr1});
            chk($sformatf("v%0d_sval1", i), search_val_1, tbl[i].e_sv1);
            chk($sformatf("v%0d_sready2", i), {31'd0, search_ready_2}, {31'd0, tbl[i].e_sr2});
            chk($sformatf("v%0d_sval2", i), search_val_2, tbl[i].e_sv2);
            tick();
            chk($sformatf("v%0d_commit_ready", i), {31'd0, commit_ready}, {31'd0, tbl[i].e_cr});
            chk($sformatf("v%0d_clear", i), {31'd0, clear}, 32'd0);
            if (tbl[i].e_cr) begin
                chk($sformatf("v%0d_commit_reg", i), {27'd0, commit_reg_id}, {27'd0, tbl[i].e_creg});
                chk($sformatf("v%0d_commit_val", i), commit_val, tbl[i].e_cval);
                chk($sformatf("v%0d_commit_id", i), {28'd0, commit_rob_id}, {28'd0, tbl[i].e_cid});
            end
        end

        // Fill all 16 entries, reject a 17th, free one and wrap to id 0.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("fill%0d_id", i), {28'd0, issue_rob_id}, i);
            chk($sformatf("fill%0d_full", i), {31'd0, rob_full}, 32'd0);
            issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'(i + 1);
            tick();
        end
        chk("full_after16", {31'd0, rob_full}, 32'd1);
        chk("full_tail_wrapped", {28'd0, issue_rob_id}, 32'd0);
        issue_rd = 5'd31;
        tick();
        chk("full_17th_ignored", {31'd0, rob_full}, 32'd1);
        chk("full_17th_tail", {28'd0, issue_rob_id}, 32'd0);
        issue_valid = 1'b0;
        wb_valid = 1'b1; wb_rob_id = 4'd0; wb_val = 32'hAAAA;
        tick();
        wb_valid = 1'b0;
        // Commit cycle: the slot being freed must not admit this issue.
        issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd30;
        #1;
        chk("commit_cycle_full", {31'd0, rob_full}, 32'd1);
        tick();
        issue_valid = 1'b0;
        chk("wrap_commit_ready", {31'd0, commit_ready}, 32'd1);
        chk("wrap_commit_reg", {27'd0, commit_reg_id}, 32'd1);
        chk("wrap_commit_val", commit_val, 32'hAAAA);
        chk("wrap_commit_id", {28'd0, commit_rob_id}, 32'd0);
        chk("wrap_not_full", {31'd0, rob_full}, 32'd0);
        chk("wrap_next_id", {28'd0, issue_rob_id}, 32'd0);
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        issue_valid = 1'b0;
        chk("wrap_refull", {31'd0, rob_full}, 32'd1);
        chk("wrap_pulse_end", {31'd0, commit_ready}, 32'd0);

        // Mispredicted branch at id 0; rdy_in low first holds everything.
        do_reset();
        issue_valid = 1'b1; issue_has_rd = 1'b0; issue_is_branch = 1'b1; issue_pred_taken = 1'b0;
        tick();
        issue_has_rd = 1'b1; issue_rd = 5'd7; issue_is_branch = 1'b0;
        tick();
        idle();
        wb_valid = 1'b1; wb_rob_id = 4'd0; wb_taken = 1'b1; wb_target = 32'h80; wb_val = 32'h0;
        tick();
        idle();
        rdy_in = 1'b0;
        tick();
        chk("frozen_commit", {31'd0, commit_ready}, 32'd0);
        chk("frozen_clear", {31'd0, clear}, 32'd0);
        chk("frozen_issue_id", {28'd0, issue_rob_id}, 32'd2);
        rdy_in = 1'b1;
        issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd9;
        wb_valid = 1'b1; wb_rob_id = 4'd1; wb_val = 32'h77;
        tick();
        idle();
        search_rob_id_1 = 4'd1;
        #1;
        chk("br_clear", {31'd0, clear}, 32'd1);
        chk("br_redirect", redirect_pc, 32'h80);
        chk("br_commit_ready", {31'd0, commit_ready}, 32'd1);
        chk("br_commit_reg", {27'd0, commit_reg_id}, 32'd0);
        chk("br_commit_id", {28'd0, commit_rob_id}, 32'd0);
        chk("br_issue_id", {28'd0, issue_rob_id}, 32'd0);
        chk("br_not_full", {31'd0, rob_full}, 32'd0);
        chk("br_flushed_entry", {31'd0, search_ready_1}, 32'd0);
        tick();
        chk("br_clear_pulse", {31'd0, clear}, 32'd0);
        chk("br_no_more_commit", {31'd0, commit_ready}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
